fp_round_pipe: RTL

- Pipelined, parametrised linear-to-floating-point converter with rounding.
- Takes a two's-complement sample and produces a sign/exponent/significand triple (value = F * 2^E, negated if S) with selectable rounding and saturation.
- Generalises the team's combinational 12-bit/3-bit/4-bit rounding stage to arbitrary widths, adds rounding modes, a saturation flag and a valid/ready stream interface.
- Sits between the sample front-end and the compressed-storage path.

---
 rtl/fp_round_pipe.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/fp_round_pipe.sv
// Three-stage linear-to-float converter: sign/magnitude, leading-one extract, round/saturate.
// Valid/ready stream with a single global advance; out_* hold while stalled.
module fp_round_pipe #(
    parameter int IN_W  = 12,
    parameter int EXP_W = 3,
    parameter int SIG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       round_mode,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_s,
    output logic [EXP_W-1:0] out_e,
    output logic [SIG_W-1:0] out_f,
    output logic             out_sat,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int EW = $clog2(IN_W) + 1;
    localparam int CW = ((EW > EXP_W) ? EW : EXP_W) + 1;
    localparam logic [EW-1:0]    SIG_E  = EW'(SIG_W);
    localparam logic [EW-1:0]    SHIFT0 = EW'(SIG_W - 1);
    localparam logic [IN_W-1:0]  ONE_M  = IN_W'(1);
    localparam logic [SIG_W-1:0] ONE_F  = SIG_W'(1);
    localparam logic [CW-1:0]    E_MAX  = CW'((1 << EXP_W) - 1);

    typedef enum logic [1:0] {
        RM_HALF_UP = 2'd0,
        RM_TRUNC   = 2'd1,
        RM_EVEN    = 2'd2,
        RM_RSVD    = 2'd3
    } rmode_e;

    logic adv;

    logic             s1_vld_q, s1_sgn_q;
    logic [IN_W-1:0]  s1_mag_q, s1_mag_d;
    rmode_e           s1_mode_q;

    logic             s2_vld_q, s2_sgn_q;
    rmode_e           s2_mode_q;
    logic [EW-1:0]    s2_e_q, s2_e_d;
    logic [SIG_W-1:0] s2_f_q, s2_f_d;
    logic             s2_rb_q, s2_rb_d, s2_st_q, s2_st_d;

    logic             out_vld_q, out_s_q, out_sat_q, out_sat_d;
    logic [EXP_W-1:0] out_e_q, out_e_d;
    logic [SIG_W-1:0] out_f_q, out_f_d;

    logic [EW-1:0]    msb;
    logic [IN_W-1:0]  rb_mask;
    logic             inc;
    logic [EW-1:0]    e_n;
    logic [SIG_W-1:0] f_n;
    logic [CW-1:0]    e_ext;

    assign adv      = !out_vld_q || out_ready;
    assign in_ready = adv;

    assign s1_mag_d = in_data[IN_W-1] ? -in_data : in_data;

    always_comb begin
        msb     = '0;
        rb_mask = '0;
        s2_e_d  = '0;
        s2_f_d  = s1_mag_q[SIG_W-1:0];
        s2_rb_d = 1'b0;
        s2_st_d = 1'b0;
        for (int unsigned i = 0; i < IN_W; i++) begin
            if (s1_mag_q[i]) msb = EW'(i);
        end
        // mag=0 leaves msb=0, which always falls into the unshifted branch
        if (msb >= SIG_E) begin
            s2_e_d  = msb - SHIFT0;
            s2_f_d  = SIG_W'(s1_mag_q >> s2_e_d);
            rb_mask = ONE_M << (s2_e_d - EW'(1));
            s2_rb_d = |(s1_mag_q & rb_mask);
            s2_st_d = |(s1_mag_q & (rb_mask - ONE_M));
        end
    end

    always_comb begin
        case (s2_mode_q)
            RM_TRUNC: inc = 1'b0;
            RM_EVEN:  inc = s2_rb_q & (s2_st_q | s2_f_q[0]);
            default:  inc = s2_rb_q;
        endcase
        e_n = s2_e_q;
        f_n = s2_f_q;
        if (inc && (&s2_f_q)) begin
            f_n = ONE_F << (SIG_W - 1);
            e_n = s2_e_q + EW'(1);
        end else if (inc) begin
            f_n = s2_f_q + ONE_F;
        end
        e_ext     = CW'(e_n);
        out_sat_d = e_ext > E_MAX;
        out_e_d   = out_sat_d ? '1 : e_ext[EXP_W-1:0];
        out_f_d   = out_sat_d ? '1 : f_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q  <= 1'b0;
            s1_sgn_q  <= 1'b0;
            s1_mag_q  <= '0;
            s1_mode_q <= RM_HALF_UP;
            s2_vld_q  <= 1'b0;
            s2_sgn_q  <= 1'b0;
            s2_mode_q <= RM_HALF_UP;
            s2_e_q    <= '0;
            s2_f_q    <= '0;
            s2_rb_q   <= 1'b0;
            s2_st_q   <= 1'b0;
            out_vld_q <= 1'b0;
            out_s_q   <= 1'b0;
            out_e_q   <= '0;
            out_f_q   <= '0;
            out_sat_q <= 1'b0;
        end else if (adv) begin
            s1_vld_q  <= in_valid;
            s1_sgn_q  <= in_data[IN_W-1];
            s1_mag_q  <= s1_mag_d;
            s1_mode_q <= rmode_e'(round_mode);
            s2_vld_q  <= s1_vld_q;
            s2_sgn_q  <= s1_sgn_q;
            s2_mode_q <= s1_mode_q;
            s2_e_q    <= s2_e_d;
            s2_f_q    <= s2_f_d;
            s2_rb_q   <= s2_rb_d;
            s2_st_q   <= s2_st_d;
            out_vld_q <= s2_vld_q;
            out_s_q   <= s2_sgn_q;
            out_e_q   <= out_e_d;
            out_f_q   <= out_f_d;
            out_sat_q <= out_sat_d;
        end
    end

    assign out_valid = out_vld_q;
    assign out_s     = out_s_q;
    assign out_e     = out_e_q;
    assign out_f     = out_f_q;
    assign out_sat   = out_sat_q;

endmodule
